// File: rtl/wave_frame_tx_pkg.sv
// Shared definitions for the A-scan frame transmitter: state encoding,
// header geometry and default sync bytes.
package wave_frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY_LO,
        ST_PAY_HI,
        ST_CSUM
    } state_t;

    localparam int         HDR_LEN   = 5;
    localparam logic [7:0] SYNC0_DEF = 8'hA5;
    localparam logic [7:0] SYNC1_DEF = 8'h5A;

endpackage

// File: rtl/wave_frame_tx_if.sv
// Capture-FIFO read port and byte-stream tx port of the frame transmitter.
// master = transmitter side, slave = FIFO/sink side.
interface wave_frame_tx_if;

    logic [15:0] i_fifo_data;
    logic        i_fifo_empty;
    logic        o_fifo_rd;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;

    modport master (
        input  i_fifo_data, i_fifo_empty, i_tx_ready,
        output o_fifo_rd, o_tx_data, o_tx_valid
    );

    modport slave (
        output i_fifo_data, i_fifo_empty, i_tx_ready,
        input  o_fifo_rd, o_tx_data, o_tx_valid
    );

endinterface

// File: rtl/wave_frame_tx_byte_reg.sv
// Registered output byte: accepts a new value whenever empty or the current
// byte is being taken, otherwise holds data/valid stable.
module tx_byte_reg (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ld_valid_i,
    input  logic [7:0] ld_data_i,
    input  logic       ready_i,
    output logic       valid_o,
    output logic [7:0] data_o
);

    logic       valid_q, valid_d;
    logic [7:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (!valid_q || ready_i) begin
            valid_d = ld_valid_i;
            data_d  = ld_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/wave_frame_tx.sv
// Frames capture-FIFO words as: SYNC0 SYNC1 seq lenH lenL payload... csum.
// state_q/idx_q name the byte slot held (or awaited) in the output register.
module wave_frame_tx
    import wave_frame_tx_pkg::*;
#(
    parameter logic [7:0] SYNC0 = SYNC0_DEF,
    parameter logic [7:0] SYNC1 = SYNC1_DEF,
    parameter int         CNT_W = 16
) (
    input  logic              i_rd_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_recv_count,
    wave_frame_tx_if.master   bus,
    output logic              o_busy,
    output logic              o_overrun
);

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] bytes_q, bytes_d;
    logic [7:0]       csum_q, csum_d;
    logic [7:0]       seq_q, seq_d;
    logic             st_q;
    logic             ovr_q, ovr_d;

    logic       tx_valid;
    logic [7:0] tx_data;
    logic       xfer, pop, start_edge;
    logic       ld_valid;
    logic [7:0] ld_data;

    assign xfer       = tx_valid & bus.i_tx_ready;
    assign pop        = xfer & (state_q == ST_PAY_HI);
    assign start_edge = i_start & ~st_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        bytes_d = bytes_q;
        csum_d  = csum_q;
        seq_d   = seq_q;
        ovr_d   = start_edge & (state_q != ST_IDLE);

        if (xfer && (state_q == ST_PAY_LO || state_q == ST_PAY_HI))
            csum_d = csum_q + tx_data;

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d = ST_HDR;
                    idx_d   = 3'd0;
                    len_d   = i_recv_count & ~CNT_W'(1);
                    bytes_d = '0;
                    csum_d  = 8'h00;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    if (idx_q == 3'(HDR_LEN - 1))
                        state_d = (len_q != '0) ? ST_PAY_LO : ST_CSUM;
                    else
                        idx_d = idx_q + 3'd1;
                end
            end
            ST_PAY_LO: begin
                if (xfer) state_d = ST_PAY_HI;
            end
            ST_PAY_HI: begin
                if (xfer) begin
                    bytes_d = bytes_q + CNT_W'(2);
                    state_d = (bytes_q + CNT_W'(2) == len_q) ? ST_CSUM : ST_PAY_LO;
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    seq_d   = seq_q + 8'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Byte for the slot being entered; the word just popped is stale,
        // so PAY_LO waits a cycle for the FIFO to show the next one.
        ld_valid = 1'b0;
        ld_data  = 8'h00;
        case (state_d)
            ST_HDR: begin
                ld_valid = 1'b1;
                case (idx_d)
                    3'd0:    ld_data = SYNC0;
                    3'd1:    ld_data = SYNC1;
                    3'd2:    ld_data = seq_q;
                    3'd3:    ld_data = len_q[15:8];
                    default: ld_data = len_q[7:0];
                endcase
            end
            ST_PAY_LO: begin
                ld_valid = ~bus.i_fifo_empty & ~pop;
                ld_data  = ld_valid ? bus.i_fifo_data[7:0] : 8'h00;
            end
            ST_PAY_HI: begin
                ld_valid = 1'b1;
                ld_data  = bus.i_fifo_data[15:8];
            end
            ST_CSUM: begin
                ld_valid = 1'b1;
                ld_data  = csum_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_rd_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            len_q   <= '0;
            bytes_q <= '0;
            csum_q  <= 8'h00;
            seq_q   <= 8'h00;
            st_q    <= 1'b1;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            bytes_q <= bytes_d;
            csum_q  <= csum_d;
            seq_q   <= seq_d;
            st_q    <= i_start;
            ovr_q   <= ovr_d;
        end
    end

    tx_byte_reg u_out (
        .clk_i      (i_rd_clk),
        .rst_i      (i_rst),
        .ld_valid_i (ld_valid),
        .ld_data_i  (ld_data),
        .ready_i    (bus.i_tx_ready),
        .valid_o    (tx_valid),
        .data_o     (tx_data)
    );

    assign bus.o_tx_valid = tx_valid;
    assign bus.o_tx_data  = tx_data;
    assign bus.o_fifo_rd  = pop;
    assign o_busy         = (state_q != ST_IDLE);
    assign o_overrun      = ovr_q;

endmodule

// File: tb/tb_wave_frame_tx.sv
// Randomized bench for wave_frame_tx: a frame-level model builds the expected
// byte stream per request and a negedge monitor compares every transfer.
module tb_wave_frame_tx;

    typedef struct packed {
        logic [7:0] b;
        logic       pop;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b1;
    logic [15:0] recv_count = 16'h0;
    logic        busy, ovr;

    wave_frame_tx_if bus();

    wave_frame_tx #(.SYNC0(8'hA5), .SYNC1(8'h5A), .CNT_W(16)) dut (
        .i_rd_clk     (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_recv_count (recv_count),
        .bus          (bus),
        .o_busy       (busy),
        .o_overrun    (ovr)
    );

    always #5 clk = ~clk;

    int          tests = 0, fails = 0;
    int          pop_cnt = 0, ovr_cnt = 0, rdy_mode = 0;
    bit          pop_s = 1'b0;
    exp_t        expq[$];
    logic [15:0] fifo_q[$];
    logic [15:0] wq[$];
    logic [7:0]  log_q[$], poplog[$];
    logic [7:0]  model_seq = 8'h00;
    logic        prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0]  prev_d = 8'h00;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endfunction

    function automatic void push_b(input logic [7:0] b, input logic p);
        exp_t e;
        e.b   = b;
        e.pop = p;
        expq.push_back(e);
    endfunction

    // Frame as the host must see it, from the request and the queued words.
    task automatic build_frame(input logic [15:0] cnt);
        logic [15:0] len;
        logic [15:0] w;
        logic [7:0]  sum;
        len = cnt & 16'hFFFE;
        sum = 8'h00;
        push_b(8'hA5, 1'b0);
        push_b(8'h5A, 1'b0);
        push_b(model_seq, 1'b0);
        push_b(len[15:8], 1'b0);
        push_b(len[7:0], 1'b0);
        for (int i = 0; i < int'(len) / 2; i++) begin
            w = wq[i];
            push_b(w[7:0], 1'b0);
            push_b(w[15:8], 1'b1);
            sum = sum + w[7:0] + w[15:8];
        end
        push_b(sum, 1'b0);
        model_seq  = model_seq + 8'd1;
        recv_count = cnt;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string nm);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk); #1;
            if (expq.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s_timeout: busy=%0b bytes left=%0d expected none", nm, busy, expq.size());
            expq.delete();
        end
    endtask

    task automatic wait_left(input int left, input int bound, input string nm);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk); #1;
            if (expq.size() <= left) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s_timeout: bytes left=%0d expected <=%0d", nm, expq.size(), left);
        end
    endtask

    task automatic load_words(input int n, input bit rnd);
        wq.delete();
        fifo_q.delete();
        for (int i = 0; i < n; i++) begin
            wq.push_back(rnd ? 16'($urandom) : 16'(i));
            fifo_q.push_back(wq[i]);
        end
    endtask

    // Per-cycle compare against the expected stream.
    always @(negedge clk) begin : mon
        exp_t e;
        logic xf;
        if (rst) begin
            prev_v = 1'b0;
            pop_s  = 1'b0;
        end else begin
            xf = bus.o_tx_valid & bus.i_tx_ready;
            if (prev_v && !prev_r) begin
                chk("hold_valid", 32'(bus.o_tx_valid), 32'(1'b1));
                chk("hold_data", 32'(bus.o_tx_data), 32'(prev_d));
            end
            if (xf) begin
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_byte: got %0h expected no transfer at %0t", bus.o_tx_data, $time);
                end else begin
                    e = expq.pop_front();
                    chk("tx_byte", 32'(bus.o_tx_data), 32'(e.b));
                    chk("fifo_rd_on_xfer", 32'(bus.o_fifo_rd), 32'(e.pop));
                    log_q.push_back(bus.o_tx_data);
                    if (bus.o_fifo_rd) poplog.push_back(bus.o_tx_data);
                end
            end else begin
                chk("fifo_rd_no_xfer", 32'(bus.o_fifo_rd), 32'(1'b0));
            end
            if (bus.o_fifo_rd) pop_cnt++;
            if (ovr) ovr_cnt++;
            pop_s  = bus.o_fifo_rd;
            prev_v = bus.o_tx_valid;
            prev_r = bus.i_tx_ready;
            prev_d = bus.o_tx_data;
        end
    end

    // Show-ahead FIFO: pops after the edge on which the DUT read it.
    always @(posedge clk) begin
        #1;
        if (pop_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
        #1;
        bus.i_fifo_empty = (fifo_q.size() == 0);
        bus.i_fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 16'h0000;
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.i_tx_ready = 1'b1;
            1:       bus.i_tx_ready = ~bus.i_tx_ready;
            default: bus.i_tx_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d bytes outstanding", expq.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] litA [10];
        logic [7:0] s;
        bit         want_next;
        litA = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        bus.i_tx_ready   = 1'b1;
        bus.i_fifo_empty = 1'b1;
        bus.i_fifo_data  = 16'h0000;

        // Reset with start held high, then keep it high: no frame
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(bus.o_tx_valid), 32'(1'b0));
        chk("rst_data", 32'(bus.o_tx_data), 32'(8'h00));
        chk("rst_busy", 32'(busy), 32'(1'b0));
        chk("rst_overrun", 32'(ovr), 32'(1'b0));
        chk("rst_fifo_rd", 32'(bus.o_fifo_rd), 32'(1'b0));
        @(posedge clk); #1 rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("held_start_busy", 32'(busy), 32'(1'b0));
            chk("held_start_valid", 32'(bus.o_tx_valid), 32'(1'b0));
        end
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);

        // Frame A: count 4, ready=1
        ovr_cnt = 0;
        for (int pass = 0; pass < 2; pass++) begin
            rdy_mode = pass;
            wq.delete(); fifo_q.delete();
            wq.push_back(16'h0201); wq.push_back(16'h0403);
            fifo_q.push_back(16'h0201); fifo_q.push_back(16'h0403);
            log_q.delete(); poplog.delete(); pop_cnt = 0;
            build_frame(16'd4);
            pulse_start();
            wait_done(200, "frame4");
            litA[2] = 8'(pass);
            chk("frame4_len", 32'(log_q.size()), 32'd10);
            if (log_q.size() == 10)
                for (int i = 0; i < 10; i++) chk("frame4_lit", 32'(log_q[i]), 32'(litA[i]));
            chk("frame4_pops", 32'(pop_cnt), 32'd2);
            if (poplog.size() == 2) begin
                chk("frame4_pop0", 32'(poplog[0]), 32'(8'h02));
                chk("frame4_pop1", 32'(poplog[1]), 32'(8'h04));
            end
        end

        // Frame C: count 7 (len 6), FIFO runs dry after first word
        rdy_mode = 0;
        wq.delete(); fifo_q.delete();
        wq.push_back(16'h2011); wq.push_back(16'h4033); wq.push_back(16'h60F5);
        fifo_q.push_back(16'h2011);
        log_q.delete(); pop_cnt = 0;
        build_frame(16'd7);
        pulse_start();
        repeat (12) @(negedge clk);
        #1;
        chk("stall_valid", 32'(bus.o_tx_valid), 32'(1'b0));
        chk("stall_busy", 32'(busy), 32'(1'b1));
        chk("stall_pops", 32'(pop_cnt), 32'd1);
        fifo_q.push_back(16'h4033);
        repeat (6) @(negedge clk);
        fifo_q.push_back(16'h60F5);
        wait_done(200, "frame6");
        chk("frame6_pops", 32'(pop_cnt), 32'd3);
        chk("frame6_len", 32'(log_q.size()), 32'd12);
        if (log_q.size() == 12) begin
            chk("frame6_lenlo", 32'(log_q[4]), 32'(8'h06));
            chk("frame6_csum", 32'(log_q[11]), 32'(8'hF9));
        end

        // Overrun: start edge mid-payload
        rdy_mode = 2;
        load_words(4, 1'b1);
        build_frame(16'd8);
        pulse_start();
        wait_left(6, 300, "ovr_reach");
        pulse_start();
        wait_done(300, "ovr_frame");
        chk("overrun_pulses", 32'(ovr_cnt), 32'd1);

        // Random frames, random ready
        ovr_cnt = 0;
        for (int f = 0; f < 20; f++) begin
            load_words(12, 1'b1);
            build_frame(16'($urandom_range(0, 24)));
            pulse_start();
            wait_done(400, "rand_frame");
        end
        chk("rand_no_overrun", 32'(ovr_cnt), 32'd0);

        // Empty frames across the sequence wrap
        rdy_mode  = 0;
        pop_cnt   = 0;
        want_next = 1'b0;
        fifo_q.delete();
        for (int f = 0; f < 256; f++) begin
            s = model_seq;
            log_q.delete();
            wq.delete();
            build_frame(16'd0);
            pulse_start();
            wait_done(50, "len0_frame");
            if (log_q.size() == 6) begin
                if (want_next) begin
                    chk("seq_wrap_00", 32'(log_q[2]), 32'(8'h00));
                    want_next = 1'b0;
                end
                if (s == 8'hFF) begin
                    chk("seq_ff", 32'(log_q[2]), 32'(8'hFF));
                    want_next = 1'b1;
                end
            end else begin
                chk("len0_size", 32'(log_q.size()), 32'd6);
            end
        end
        chk("len0_pops", 32'(pop_cnt), 32'd0);

        // Reset mid-payload, then a fresh frame
        load_words(4, 1'b1);
        build_frame(16'd8);
        pulse_start();
        wait_left(5, 100, "rst_reach");
        @(posedge clk); #1 rst = 1'b1;
        expq.delete(); fifo_q.delete();
        model_seq = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_valid", 32'(bus.o_tx_valid), 32'(1'b0));
        chk("midrst_busy", 32'(busy), 32'(1'b0));
        @(posedge clk); #1 rst = 1'b0;
        load_words(2, 1'b1);
        log_q.delete();
        build_frame(16'd4);
        pulse_start();
        wait_done(100, "post_rst");
        if (log_q.size() == 10) begin
            chk("post_rst_sync0", 32'(log_q[0]), 32'(8'hA5));
            chk("post_rst_seq", 32'(log_q[2]), 32'(8'h00));
        end else begin
            chk("post_rst_len", 32'(log_q.size()), 32'd10);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
